// File: rtl/i2s_receiver_if.sv
// I2S capture bus: ADC pads and enable in, paired stereo samples and status out.
// The receiver takes the slave modport; the ADC side / host drives through master.
interface i2s_receiver_if;
  logic               en;
  logic               sclk_in;
  logic               lrclk_in;
  logic               sdout_in;
  logic signed [15:0] audio_l;
  logic signed [15:0] audio_r;
  logic               frame_valid;
  logic               locked;
  logic               short_err;

  modport master (
    output en, sclk_in, lrclk_in, sdout_in,
    input  audio_l, audio_r, frame_valid, locked, short_err
  );

  modport slave (
    input  en, sclk_in, lrclk_in, sdout_in,
    output audio_l, audio_r, frame_valid, locked, short_err
  );
endinterface

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples the ADC bit clock in the clk domain, locks on a
// word-select change and delivers 16-bit left/right samples as a pair.
module i2s_receiver (
  input logic            clk,
  input logic            rst_n,
  i2s_receiver_if.slave  bus
);

  localparam int         DATA_W = 16;
  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] RUN    = 1'b1;

  logic [2:0]               sclk_q, sclk_d;
  logic [1:0]               ws_q, ws_d;
  logic [1:0]               sd_q, sd_d;
  logic                     ws_prev_q, ws_prev_d;
  logic                     ws_seen_q, ws_seen_d;
  logic [0:0]               state_q, state_d;
  logic [4:0]               bit_idx_q, bit_idx_d;
  logic signed [DATA_W-1:0] shift_q, shift_d;
  logic signed [DATA_W-1:0] stage_l_q, stage_l_d;
  logic                     stage_vld_q, stage_vld_d;
  logic signed [DATA_W-1:0] audio_l_q, audio_l_d;
  logic signed [DATA_W-1:0] audio_r_q, audio_r_d;
  logic                     frame_valid_q, frame_valid_d;
  logic                     short_err_q, short_err_d;

  logic                     rise;
  logic                     ws_s;
  logic                     sd_s;
  logic                     ws_change;
  logic signed [DATA_W-1:0] word_w;

  // Bits beyond the 16th of a long word are dropped, keeping the word MSB-aligned.
  function automatic logic signed [DATA_W-1:0] insert_bit(
    input logic signed [DATA_W-1:0] word,
    input logic [4:0]               idx,
    input logic                     b
  );
    logic signed [DATA_W-1:0] w;
    w = word;
    if (idx < 5'd16) w[4'd15 - idx[3:0]] = b;
    return w;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] idx);
    return (idx == 5'd31) ? idx : idx + 5'd1;
  endfunction

  // Synchroniser stage: sclk_q[1] is the synchronised bit clock, sclk_q[2] its previous value.
  assign rise      = sclk_q[1] & ~sclk_q[2];
  assign ws_s      = ws_q[1];
  assign sd_s      = sd_q[1];
  assign ws_change = rise & ws_seen_q & (ws_s != ws_prev_q);
  assign word_w    = insert_bit(shift_q, bit_idx_q, sd_s);

  // Capture stage: word assembly, staging and pair output on each bit-clock rise.
  always_comb begin
    sclk_d        = {sclk_q[1:0], bus.sclk_in};
    ws_d          = {ws_q[0], bus.lrclk_in};
    sd_d          = {sd_q[0], bus.sdout_in};
    ws_prev_d     = ws_prev_q;
    ws_seen_d     = ws_seen_q;
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    stage_l_d     = stage_l_q;
    stage_vld_d   = stage_vld_q;
    audio_l_d     = audio_l_q;
    audio_r_d     = audio_r_q;
    frame_valid_d = 1'b0;
    short_err_d   = short_err_q;

    if (rise) begin
      ws_prev_d = ws_s;
      ws_seen_d = 1'b1;
    end

    if (!bus.en) begin
      state_d     = HUNT;
      bit_idx_d   = '0;
      shift_d     = '0;
      stage_vld_d = 1'b0;
    end else if (state_q == HUNT) begin
      bit_idx_d = '0;
      shift_d   = '0;
      if (ws_change) state_d = RUN;
    end else if (rise) begin
      if (ws_change) begin
        bit_idx_d = '0;
        shift_d   = '0;
        if (bit_idx_q < 5'd15) short_err_d = 1'b1;
        if (!ws_prev_q) begin
          stage_l_d   = word_w;
          stage_vld_d = 1'b1;
        end else if (stage_vld_q) begin
          audio_r_d     = word_w;
          audio_l_d     = stage_l_q;
          frame_valid_d = 1'b1;
        end
      end else begin
        shift_d   = word_w;
        bit_idx_d = sat_inc(bit_idx_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q        <= '0;
      ws_q          <= '0;
      sd_q          <= '0;
      ws_prev_q     <= 1'b0;
      ws_seen_q     <= 1'b0;
      state_q       <= HUNT;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      stage_l_q     <= '0;
      stage_vld_q   <= 1'b0;
      audio_l_q     <= '0;
      audio_r_q     <= '0;
      frame_valid_q <= 1'b0;
      short_err_q   <= 1'b0;
    end else begin
      sclk_q        <= sclk_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      ws_prev_q     <= ws_prev_d;
      ws_seen_q     <= ws_seen_d;
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      stage_l_q     <= stage_l_d;
      stage_vld_q   <= stage_vld_d;
      audio_l_q     <= audio_l_d;
      audio_r_q     <= audio_r_d;
      frame_valid_q <= frame_valid_d;
      short_err_q   <= short_err_d;
    end
  end

  assign bus.audio_l     = audio_l_q;
  assign bus.audio_r     = audio_r_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.locked      = (state_q == RUN);
  assign bus.short_err   = short_err_q;

endmodule
